// File: rtl/sb_arbiter_if.sv
// Per-master system-bus port of sb_arbiter.
// Handshake: the master raises req with addr/wr/wdata and holds them stable until gnt pulses for one
// cycle; gnt is the only accept indication. read_valid and err are one-cycle response pulses, and
// read_data holds its value between read_valid pulses.
interface sb_arbiter_if;
  logic [31:0] addr;
  logic        req;
  logic        wr;
  logic [31:0] wdata;
  logic        gnt;
  logic [31:0] read_data;
  logic        read_valid;
  logic        err;

  modport master (
    output addr, req, wr, wdata,
    input  gnt, read_data, read_valid, err
  );

  modport slave (
    input  addr, req, wr, wdata,
    output gnt, read_data, read_valid, err
  );
endinterface

// File: rtl/sb_arbiter.sv
// Round-robin arbiter and address decoder: two bus masters onto a read-only ROM and a RAM,
// one outstanding transaction, error responses for illegal accesses and read timeouts.
module sb_arbiter #(
  parameter logic [31:0] ROM_BASE = 32'h0000_0000,
  parameter int          ROM_AW   = 16,
  parameter logic [31:0] RAM_BASE = 32'h1000_0000,
  parameter int          RAM_AW   = 16,
  parameter int          TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  sb_arbiter_if.slave m0,
  sb_arbiter_if.slave m1,
  output logic        rom_req,
  output logic [31:0] rom_addr,
  input  logic [31:0] rom_read_data,
  input  logic        rom_read_valid,
  output logic        ram_req,
  output logic        ram_wr,
  output logic [31:0] ram_addr,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_read_data,
  input  logic        ram_read_valid,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_ERR   = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  localparam int          CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [31:0] ROM_MASK = 32'((64'd1 << ROM_AW) - 64'd1);
  localparam logic [31:0] RAM_MASK = 32'((64'd1 << RAM_AW) - 64'd1);

  logic [1:0]       m_req;
  logic [1:0]       m_wr;
  logic [1:0][31:0] m_addr;
  logic [1:0][31:0] m_wdata;

  assign m_req   = {m1.req, m0.req};
  assign m_wr    = {m1.wr, m0.wr};
  assign m_addr  = {m1.addr, m0.addr};
  assign m_wdata = {m1.wdata, m0.wdata};

  state_e           state_q, state_d;
  logic             last_q, last_d;
  logic             own_q, own_d;
  logic             sel_ram_q, sel_ram_d;
  logic             wr_q, wr_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       err_q, err_d;
  logic [1:0]       rvalid_q, rvalid_d;
  logic [1:0][31:0] rdata_q, rdata_d;
  logic             rom_req_q, rom_req_d;
  logic [31:0]      rom_addr_q, rom_addr_d;
  logic             ram_req_q, ram_req_d;
  logic             ram_wr_q, ram_wr_d;
  logic [31:0]      ram_addr_q, ram_addr_d;
  logic [31:0]      ram_wdata_q, ram_wdata_d;

  // The master that did not win last time wins a tie; a lone requester always wins.
  logic        win;
  logic [31:0] win_addr;
  logic        win_wr;
  logic        rom_hit;
  logic        ram_hit;
  logic        slv_valid;
  logic [31:0] slv_data;

  assign win       = (m_req[0] & m_req[1]) ? ~last_q : m_req[1];
  assign win_addr  = m_addr[win];
  assign win_wr    = m_wr[win];
  assign rom_hit   = (win_addr[31:ROM_AW] == ROM_BASE[31:ROM_AW]);
  assign ram_hit   = (win_addr[31:RAM_AW] == RAM_BASE[31:RAM_AW]);
  assign slv_valid = sel_ram_q ? ram_read_valid : rom_read_valid;
  assign slv_data  = sel_ram_q ? ram_read_data : rom_read_data;

  // Outputs are computed one cycle ahead and registered, so ISSUE/ERR pulses line up with the state.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    own_d       = own_q;
    sel_ram_d   = sel_ram_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    gnt_d       = '0;
    err_d       = '0;
    rvalid_d    = '0;
    rdata_d     = rdata_q;
    rom_req_d   = 1'b0;
    rom_addr_d  = '0;
    ram_req_d   = 1'b0;
    ram_wr_d    = 1'b0;
    ram_addr_d  = '0;
    ram_wdata_d = '0;

    unique case (state_q)
      S_IDLE: begin
        if (|m_req) begin
          own_d      = win;
          last_d     = win;
          wr_d       = win_wr;
          cnt_d      = '0;
          gnt_d[win] = 1'b1;
          if (rom_hit && !win_wr) begin
            state_d    = S_ISSUE;
            sel_ram_d  = 1'b0;
            rom_req_d  = 1'b1;
            rom_addr_d = win_addr & ROM_MASK;
          end else if (!rom_hit && ram_hit) begin
            state_d     = S_ISSUE;
            sel_ram_d   = 1'b1;
            ram_req_d   = 1'b1;
            ram_wr_d    = win_wr;
            ram_addr_d  = win_addr & RAM_MASK;
            ram_wdata_d = m_wdata[win];
          end else begin
            state_d    = S_ERR;
            err_d[win] = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = wr_q ? S_IDLE : S_WAIT;
      S_ERR:   state_d = S_IDLE;
      S_WAIT: begin
        if (slv_valid) begin
          state_d          = S_IDLE;
          rvalid_d[own_q]  = 1'b1;
          rdata_d[own_q]   = slv_data;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d      = S_IDLE;
          err_d[own_q] = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      last_q      <= 1'b1;
      own_q       <= 1'b0;
      sel_ram_q   <= 1'b0;
      wr_q        <= 1'b0;
      cnt_q       <= '0;
      gnt_q       <= '0;
      err_q       <= '0;
      rvalid_q    <= '0;
      rdata_q     <= '0;
      rom_req_q   <= 1'b0;
      rom_addr_q  <= '0;
      ram_req_q   <= 1'b0;
      ram_wr_q    <= 1'b0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      own_q       <= own_d;
      sel_ram_q   <= sel_ram_d;
      wr_q        <= wr_d;
      cnt_q       <= cnt_d;
      gnt_q       <= gnt_d;
      err_q       <= err_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      rom_req_q   <= rom_req_d;
      rom_addr_q  <= rom_addr_d;
      ram_req_q   <= ram_req_d;
      ram_wr_q    <= ram_wr_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
    end
  end

  assign m0.gnt        = gnt_q[0];
  assign m0.err        = err_q[0];
  assign m0.read_valid = rvalid_q[0];
  assign m0.read_data  = rdata_q[0];
  assign m1.gnt        = gnt_q[1];
  assign m1.err        = err_q[1];
  assign m1.read_valid = rvalid_q[1];
  assign m1.read_data  = rdata_q[1];

  assign rom_req     = rom_req_q;
  assign rom_addr    = rom_addr_q;
  assign ram_req     = ram_req_q;
  assign ram_wr      = ram_wr_q;
  assign ram_addr    = ram_addr_q;
  assign ram_wdata   = ram_wdata_q;
  assign dbg_state_o = state_q;

endmodule
